// File: rtl/alarm_clock_ctrl.sv
// Moore control FSM for the alarm clock: keypad entry, alarm/time load, alarm display.
// Optional macro ALARM_CTRL_DIGIT_LIMIT_EN caps an entry at four accepted digits.
module alarm_clock_ctrl #(
  parameter int TIMEOUT = 10,
  parameter int CNT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       reset_count,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_a,
  output logic       show_new_time,
  output logic       shift,
  output logic [2:0] digit_count
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAIT,
    KEY_ENTRY,
    SET_ALARM_TIME,
    SET_CURRENT_TIME,
    SHOW_ALARM
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] tmo_cnt_reg;
  logic             digit_key, in_entry, timeout, digit_full;

  assign digit_key = (key <= 4'd9);
  assign in_entry  = (state_reg == KEY_WAIT) || (state_reg == KEY_ENTRY);
  assign timeout   = in_entry && one_second && (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));

`ifdef ALARM_CTRL_DIGIT_LIMIT_EN
  logic [2:0] digit_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset || state_next == SHOW_TIME)
      digit_cnt_reg <= 3'd0;
    else if (state_reg == KEY_STORED)
      digit_cnt_reg <= digit_cnt_reg + 3'd1;
  end

  assign digit_full  = (digit_cnt_reg >= 3'd4);
  assign digit_count = digit_cnt_reg;
`else
  assign digit_full  = 1'b0;
  assign digit_count = 3'd0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SHOW_TIME: begin
        if (alarm_button)   state_next = SHOW_ALARM;
        else if (digit_key) state_next = KEY_STORED;
      end
      KEY_STORED:       state_next = KEY_WAIT;
      KEY_WAIT: begin
        if (timeout)         state_next = SHOW_TIME;
        else if (!digit_key) state_next = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        // Buttons outrank a digit; a full entry keeps waiting for a button.
        if (timeout)                       state_next = SHOW_TIME;
        else if (alarm_button)             state_next = SET_ALARM_TIME;
        else if (time_button)              state_next = SET_CURRENT_TIME;
        else if (digit_key && !digit_full) state_next = KEY_STORED;
      end
      SET_ALARM_TIME:   state_next = SHOW_TIME;
      SET_CURRENT_TIME: state_next = SHOW_TIME;
      SHOW_ALARM: begin
        if (!alarm_button) state_next = SHOW_TIME;
      end
      default:          state_next = SHOW_TIME;
    endcase
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= SHOW_TIME;
      shift         <= 1'b0;
      show_new_time <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      reset_count   <= 1'b0;
      show_a        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift         <= (state_next == KEY_STORED);
      show_new_time <= (state_next == KEY_WAIT) || (state_next == KEY_ENTRY);
      load_new_a    <= (state_next == SET_ALARM_TIME);
      load_new_c    <= (state_next == SET_CURRENT_TIME);
      reset_count   <= (state_next == SET_CURRENT_TIME);
      show_a        <= (state_next == SHOW_ALARM);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || (state_next != KEY_WAIT && state_next != KEY_ENTRY))
      tmo_cnt_reg <= '0;
    else if (in_entry && one_second)
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: directed scenarios plus random traffic against an
// entry-session reference model; every cycle's outputs are compared.
module tb_alarm_clock_ctrl;
  localparam int TIMEOUT = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'd15;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       reset_count, load_new_a, load_new_c, show_a, show_new_time, shift;
  logic [2:0] digit_count;

  int    checks = 0;
  int    errors = 0;
  string tag = "reset";
  int    shift_seen = 0;
  int    loadc_seen = 0;

  // Reference model: an entry session with a pending shift, a key still held down,
  // elapsed idle seconds, digits accepted, and one-shot load flags.
  bit m_alarm_view, m_entry, m_fresh, m_held, m_load_a, m_load_c;
  int m_secs, m_digits;

`ifdef ALARM_CTRL_DIGIT_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  alarm_clock_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .key(key),
    .alarm_button(alarm_button), .time_button(time_button),
    .reset_count(reset_count), .load_new_a(load_new_a), .load_new_c(load_new_c),
    .show_a(show_a), .show_new_time(show_new_time), .shift(shift),
    .digit_count(digit_count)
  );

  always #5 clock = ~clock;

  function automatic void accept_digit();
    m_fresh = 1; m_held = 1; m_secs = 0; m_digits++;
  endfunction

  function automatic void model_update();
    bit is_digit = (key < 4'd10);
    if (reset) begin
      m_alarm_view = 0; m_entry = 0; m_fresh = 0; m_held = 0;
      m_load_a = 0; m_load_c = 0; m_secs = 0; m_digits = 0;
    end else if (m_load_a || m_load_c) begin
      m_load_a = 0; m_load_c = 0; m_digits = 0;
    end else if (m_alarm_view) begin
      m_alarm_view = alarm_button;
    end else if (!m_entry) begin
      if (alarm_button) m_alarm_view = 1;
      else if (is_digit) begin m_entry = 1; m_digits = 0; accept_digit(); end
    end else if (m_fresh) begin
      m_fresh = 0;
    end else if (one_second && m_secs == TIMEOUT - 1) begin
      m_entry = 0; m_held = 0; m_secs = 0; m_digits = 0;
    end else if (m_held) begin
      if (!is_digit) m_held = 0;
      if (one_second) m_secs++;
    end else if (alarm_button) begin
      m_load_a = 1; m_entry = 0; m_secs = 0;
    end else if (time_button) begin
      m_load_c = 1; m_entry = 0; m_secs = 0;
    end else if (is_digit && !(LIMIT && m_digits >= 4)) begin
      accept_digit();
    end else if (one_second) begin
      m_secs++;
    end
  endfunction

  task automatic step(input logic [3:0] k, input logic ab, input logic tb,
                      input logic os, input logic rs);
    logic [8:0] obs, exp;
    logic [2:0] exp_dc;
    @(negedge clock);
    key = k; alarm_button = ab; time_button = tb; one_second = os; reset = rs;
    @(posedge clock);
    model_update();
    #1;
    exp_dc = LIMIT ? 3'(m_fresh ? m_digits - 1 : m_digits) : 3'd0;
    exp = {m_load_c, m_load_a, m_load_c, m_alarm_view, m_entry && !m_fresh, m_fresh, exp_dc};
    obs = {reset_count, load_new_a, load_new_c, show_a, show_new_time, shift, digit_count};
    shift_seen += int'(shift);
    loadc_seen += int'(load_new_c);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {rc,la,lc,sa,snt,sh,dc}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic count_check(input string name, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd15, 0, 0, 0, 0);
  endtask

  task automatic digit(input logic [3:0] k);
    step(k, 0, 0, 0, 0);
    step(4'd15, 0, 0, 0, 0);
    step(4'd15, 0, 0, 0, 0);
  endtask

  initial begin
    step(4'd15, 0, 0, 0, 1);
    step(4'd15, 0, 0, 0, 1);
    idle(2);

    tag = "set_time";
    shift_seen = 0; loadc_seen = 0;
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
    step(4'd15, 0, 1, 0, 0);
    step(4'd15, 0, 0, 0, 0);
    idle(2);
    count_check("set_time_shifts", shift_seen, LIMIT ? 4 : 4);
    count_check("set_time_loads", loadc_seen, 1);

    tag = "held_key";
    shift_seen = 0;
    for (int i = 0; i < 20; i++) step(4'd5, 0, 0, 0, 0);
    step(4'd15, 0, 0, 0, 0);
    count_check("held_key_shifts", shift_seen, 1);

    tag = "reset_mid_entry";
    step(4'd15, 0, 0, 0, 1);
    step(4'd15, 0, 0, 0, 1);
    idle(2);

    tag = "timeout";
    digit(4'd7);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step(4'd15, 0, 0, 1, 0);
      step(4'd15, 0, 0, 0, 0);
    end
    step(4'd15, 1, 0, 1, 0);
    step(4'd15, 0, 0, 0, 0);
    idle(2);

    tag = "alarm_priority";
    digit(4'd8);
    step(4'd15, 1, 1, 0, 0);
    step(4'd15, 0, 0, 0, 0);
    idle(2);

    tag = "show_alarm";
    for (int i = 0; i < 8; i++) step(4'($urandom_range(0, 9)), 1, 0, 0, 0);
    step(4'd15, 0, 0, 0, 0);
    idle(2);

    tag = "digit_limit";
    shift_seen = 0; loadc_seen = 0;
    for (int i = 0; i < 6; i++) digit(4'(i));
    step(4'd15, 0, 1, 0, 0);
    step(4'd15, 0, 0, 0, 0);
    count_check("limit_shifts", shift_seen, LIMIT ? 4 : 6);
    count_check("limit_loads", loadc_seen, 1);

    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] k;
      k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      step(k, $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
